timer_counter: RTL

Memory-mapped programmable down-counter on the processor's peripheral bus, downstream of the CPU core's `PrAddr/PrWD/PrWE/PrBE` outputs (after the system bridge's address decode). It holds a control word, a preset value and a live count, and raises an interrupt request that the system wires into `HWInt[0]` of the core. It supports one-shot and auto-reload modes. Reads are combinational so the core's MEM stage sees `PrRD` in the same cycle.

---
 rtl/timer_counter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/timer_counter.sv
// Programmable down-counter peripheral: CTRL/PRESET/COUNT registers, one-shot or auto-reload, masked irq.
// Optional prescaler compiled in with `TC_PRESCALE_EN`; reads are combinational, writes need all byte enables.
module timer_counter #(
  parameter int PRESCALE_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  state_t      state_q, state_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        pending_q, pending_d;
  logic        wr_ok;
  logic        tick;
  logic [31:0] ctrl_rd;

`ifdef TC_PRESCALE_EN
  logic [PRESCALE_W-1:0] ps_q, ps_d;
  logic [PRESCALE_W-1:0] ps_cnt_q, ps_cnt_d;
  logic                  unused_din;

  // >= rather than == so lowering PS mid-count cannot strand the counter.
  assign tick       = (ps_cnt_q >= ps_q);
  assign unused_din = ^{din[31:8+PRESCALE_W], din[7:4]};

  always_comb begin
    ctrl_rd                  = '0;
    ctrl_rd[3:0]             = ctrl_q;
    ctrl_rd[8 +: PRESCALE_W] = ps_q;
  end
`else
  logic                  unused_din;
  logic [PRESCALE_W-1:0] unused_ps;

  assign tick       = 1'b1;
  assign ctrl_rd    = {28'd0, ctrl_q};
  assign unused_din = ^din[31:4];
  assign unused_ps  = '0;
`endif

  assign wr_ok = we && (be == 4'b1111);

  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    preset_d  = preset_q;
    count_d   = count_q;
    pending_d = pending_q;
`ifdef TC_PRESCALE_EN
    ps_d      = ps_q;
    ps_cnt_d  = ps_cnt_q;
`endif

    case (state_q)
      IDLE: if (ctrl_q.en) state_d = LOAD;
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
`ifdef TC_PRESCALE_EN
        ps_cnt_d = '0;
`endif
      end
      CNT: begin
        if (!ctrl_q.en) begin
          state_d = IDLE;
        end else if (tick) begin
`ifdef TC_PRESCALE_EN
          ps_cnt_d = '0;
`endif
          if (count_q <= 32'd1) begin
            count_d   = 32'd0;
            pending_d = 1'b1;
            state_d   = INT;
          end else begin
            count_d = count_q - 32'd1;
          end
        end else begin
`ifdef TC_PRESCALE_EN
          ps_cnt_d = ps_cnt_q + PRESCALE_W'(1);
`endif
        end
      end
      INT: begin
        if (ctrl_q.mode == 2'b01) begin
          pending_d = 1'b0;
          state_d   = LOAD;
        end else begin
          ctrl_d.en = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bus writes are applied last so they override the FSM's EN clear and pending set.
    if (wr_ok) begin
      case (addr)
        2'd0: begin
          ctrl_d    = ctrl_t'(din[3:0]);
          pending_d = 1'b0;
`ifdef TC_PRESCALE_EN
          ps_d      = din[8 +: PRESCALE_W];
`endif
        end
        2'd1: begin
          preset_d  = din;
          pending_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ctrl_q    <= '0;
      preset_q  <= '0;
      count_q   <= '0;
      pending_q <= 1'b0;
`ifdef TC_PRESCALE_EN
      ps_q      <= '0;
      ps_cnt_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      preset_q  <= preset_d;
      count_q   <= count_d;
      pending_q <= pending_d;
`ifdef TC_PRESCALE_EN
      ps_q      <= ps_d;
      ps_cnt_q  <= ps_cnt_d;
`endif
    end
  end

  always_comb begin
    case (addr)
      2'd0:    dout = ctrl_rd;
      2'd1:    dout = preset_q;
      2'd2:    dout = count_q;
      default: dout = 32'd0;
    endcase
  end

  assign irq = pending_q & ctrl_q.im;

endmodule
